// File: rtl/intdiv_lzskip.sv
// Iterative radix-2 restoring divider that skips the dividend's leading zeros.
// Optional signed mode is enabled by defining DIV_SIGNED_EN (adds the Signed input).

module lzd_hier #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]         x_i,
    output logic [$clog2(WIDTH)-1:0] zp_o,
    output logic                     zv_o
);
    localparam int PW = $clog2(WIDTH);

    // Ascending scan: the highest set bit is the last one written.
    always_comb begin
        zp_o = '0;
        zv_o = |x_i;
        for (int i = 0; i < WIDTH; i++) begin
            if (x_i[i]) zp_o = PW'(WIDTH - 1 - i);
        end
    end
endmodule

module intdiv_lzskip #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] D,
`ifdef DIV_SIGNED_EN
    input  logic             Signed,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] REM,
    output logic             DivBy0
);
    localparam int PW = $clog2(WIDTH);
    localparam int KW = PW + 1;

    typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xr_q, xr_d, dr_q, dr_d, r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d, rem_q, rem_d;
    logic [KW-1:0]    k_q, k_d;
    logic             dz_q, dz_d, sx_q, sx_d, sd_q, sd_d;

    logic [PW-1:0]    zp;
    logic             zv;
    logic [WIDTH:0]   t, diff;
    logic             qbit;
    logic [WIDTH-1:0] r_nxt, q_nxt;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    lzd_hier #(.WIDTH(WIDTH)) u_lzd (
        .x_i  (xr_q),
        .zp_o (zp),
        .zv_o (zv)
    );

    // One restoring step: R < DR keeps T - DR within WIDTH bits.
    always_comb begin
        t     = {r_q, xr_q[WIDTH-1]};
        diff  = t - {1'b0, dr_q};
        qbit  = (t >= {1'b0, dr_q});
        r_nxt = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
        q_nxt = {q_q[WIDTH-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        dr_d    = dr_q;
        r_d     = r_q;
        q_d     = q_q;
        rem_d   = rem_q;
        k_d     = k_q;
        dz_d    = dz_q;
        sx_d    = sx_q;
        sd_d    = sd_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
`ifdef DIV_SIGNED_EN
                    sx_d = Signed & X[WIDTH-1];
                    sd_d = Signed & D[WIDTH-1];
                    xr_d = neg_if(X, sx_d);
                    dr_d = neg_if(D, sd_d);
`else
                    sx_d = 1'b0;
                    sd_d = 1'b0;
                    xr_d = X;
                    dr_d = D;
`endif
                    dz_d    = 1'b0;
                    state_d = NORM;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                if (dr_q == '0) begin
                    q_d     = '1;
                    rem_d   = neg_if(xr_q, sx_q);
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else if (!zv) begin
                    q_d     = '0;
                    rem_d   = '0;
                    state_d = DONE;
                end else begin
                    xr_d    = xr_q << zp;
                    k_d     = KW'(WIDTH) - KW'(zp);
                    r_d     = '0;
                    q_d     = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                r_d  = r_nxt;
                q_d  = q_nxt;
                xr_d = xr_q << 1;
                k_d  = k_q - KW'(1);
                if (k_q == KW'(1)) begin
                    q_d     = neg_if(q_nxt, sx_q ^ sd_q);
                    rem_d   = neg_if(r_nxt, sx_q);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Working registers are only meaningful after a capture, so they carry no reset.
    always_ff @(posedge clk) begin
        xr_q <= xr_d;
        dr_q <= dr_d;
        r_q  <= r_d;
        k_q  <= k_d;
        sx_q <= sx_d;
        sd_q <= sd_d;
    end

    assign Busy   = (state_q == NORM) || (state_q == ITER);
    assign Done   = (state_q == DONE);
    assign Q      = q_q;
    assign REM    = rem_q;
    assign DivBy0 = dz_q;
endmodule
